mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL have parameter ADDR_BITS, default 10, word-index width driven to the data memory.
REQ-002 The block SHALL have port clk  input  1  rising-edge clock shared with the data memory.
REQ-003 The block SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have port req_valid  input  1  request present.
REQ-005 The block SHALL have port req_ready  output  1  request accepted on a clk edge when high with req_valid.
REQ-006 The block SHALL have port req_write  input  1  1 = store, 0 = load.
REQ-007 The block SHALL have port req_size  input  2  00 byte, 01 halfword, 10 word; 11 is treated as word.
REQ-008 The block SHALL have port req_signed  input  1  sign-extend sub-word loads.
REQ-009 The block SHALL have port req_addr  input  32  byte address.
REQ-010 The block SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-011 The block SHALL have port resp_valid  output  1  response present.
REQ-012 The block SHALL have port resp_ready  input  1  response consumed on a clk edge when high with resp_valid.
REQ-013 The block SHALL have port resp_rdata  output  32  load result; 0 for stores and errors.
REQ-014 The block SHALL have port resp_err  output  1  misaligned access.
REQ-015 The block SHALL have port mem_address  output  32  word index to memory, {zeros, req_addr[ADDR_BITS+1:2]}.
REQ-016 The block SHALL have port mem_writeEnable  output  1  memory write strobe, sampled by the memory at the clk edge.
REQ-017 The block SHALL have port mem_dataIn  output  32  memory write data.
REQ-018 The block SHALL have port mem_dataOut  input  32  combinational memory read data for mem_address.

Function
REQ-019 The FSM SHALL use states IDLE, ACCESS, WRITE and RESP; req_ready SHALL be 1 only in IDLE.
REQ-020 On acceptance in IDLE, the block SHALL latch write, size, signed, addr and wdata; it SHALL go to RESP with err=1 if misaligned (halfword with addr[0]=1, word with addr[1:0]!=0), else to ACCESS.
REQ-021 In ACCESS, mem_address SHALL be the latched word index for exactly that cycle; a load SHALL capture the lane-extracted mem_dataOut and go to RESP.
REQ-022 In ACCESS, a word store SHALL drive mem_writeEnable=1 and mem_dataIn=wdata, then go to RESP.
REQ-023 In ACCESS, a byte or halfword store SHALL capture mem_dataOut into a merge register and go to WRITE; mem_writeEnable SHALL be 0 in that cycle.
REQ-024 In WRITE, the block SHALL drive mem_writeEnable=1 and mem_dataIn=merged word, with only the addressed lanes replaced, then go to RESP.
REQ-025 Lane order SHALL be little-endian: byte at addr[1:0]=n occupies bits 8n+7:8n, and halfword at addr[1]=h occupies bits 16h+15:16h.
REQ-026 Sub-word loads SHALL zero-extend when signed=0 and sign-extend from the lane MSB when signed=1.
REQ-027 In RESP, resp_valid, resp_rdata and resp_err SHALL hold stable until resp_ready=1 at a clk edge, then the FSM SHALL return to IDLE; a new request SHALL NOT be accepted in the same edge.
REQ-028 Latency from acceptance edge to resp_valid high SHALL be 2 edges for loads, word stores and errors-free accesses, 3 edges for sub-word stores, and 1 edge for misaligned requests.
REQ-029 mem_writeEnable SHALL be 0 in IDLE, RESP, and for misaligned requests; it SHALL assert for exactly one cycle per store.
REQ-030 Address bits above ADDR_BITS+1 SHALL be ignored, so indices wrap modulo 2^ADDR_BITS.

Reset
REQ-031 While rst_n=0, the FSM SHALL be in IDLE with req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0, mem_writeEnable=0, mem_dataIn=0 and mem_address=0, all forced asynchronously.
REQ-032 Reset asserted in any state SHALL abort the transaction with no memory write, including in WRITE before the edge; no response SHALL follow.

Verification
REQ-033 Preload word 5 = 0x80FF7F01, then signed byte load at 0x15, signed byte at 0x16 and unsigned halfword at 0x16 -> resp_rdata 0x0000007F, 0xFFFFFFFF and 0x000080FF respectively, each with resp_valid 2 edges after acceptance.
REQ-034 Byte store of 0x000000AB at 0x15 -> mem_writeEnable high for one cycle (WRITE); a following word load at 0x14 returns 0x80FFAB01.
REQ-035 Word store of 0xDEADBEEF at 0x20, then load at 0x20 -> 0xDEADBEEF; mem_address=8 during ACCESS.
REQ-036 Word load at 0x22 -> resp_err=1, resp_rdata=0, mem_writeEnable never high, resp_valid 1 edge after acceptance.
REQ-037 Hold resp_ready=0 for 5 cycles after a load -> resp_valid and resp_rdata stay stable and req_ready stays 0; the FSM enters IDLE on the first resp_ready edge.
REQ-038 Assert rst_n=0 during WRITE of a byte store -> mem_writeEnable drops immediately, the memory word is unchanged, and all outputs take their reset values.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit: byte/halfword/word load-store engine in front of a single-port word memory.
// Latency: misaligned 1 edge, loads and word stores 2 edges, sub-word stores 3 edges (read-merge-write).
// Backpressure: one request in flight; req_ready is low until the response is consumed with resp_ready.
//
// Ports:
//   clk, rst_n                    clock shared with the memory, asynchronous active-low reset
//   req_valid/req_ready           request handshake; req_write, req_size, req_signed, req_addr, req_wdata
//   resp_valid/resp_ready         response handshake; resp_rdata (load result), resp_err (misaligned)
//   mem_address, mem_writeEnable,
//   mem_dataIn, mem_dataOut       word-indexed memory port; mem_dataOut is combinational for mem_address
module mem_access_unit #(
  parameter int ADDR_BITS = 10
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_address,
  output logic        mem_writeEnable,
  output logic [31:0] mem_dataIn,
  input  logic [31:0] mem_dataOut
);

  typedef enum logic [1:0] {IDLE, ACCESS, WRITE, RESP} state_t;

  state_t               state, state_nxt;
  logic                 op_write;
  logic [1:0]           op_size;
  logic                 op_signed;
  logic [ADDR_BITS+1:0] op_addr;
  logic [31:0]          op_wdata;
  logic [31:0]          merge_word;
  logic [31:0]          word_idx;
  logic                 accept;
  logic                 misaligned;
  logic                 op_sub_word;

  // Address bits above the memory index are deliberately dropped so indices wrap.
  logic unused_addr_hi;
  assign unused_addr_hi = ^req_addr[31:ADDR_BITS+2];

  // Size 11 behaves as a word, so only size 00/01 are sub-word.
  function automatic logic [31:0] load_extract(input logic [31:0] w, input logic [1:0] sz,
                                               input logic sgn, input logic [1:0] off);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = w[{off, 3'b000} +: 8];
    h = off[1] ? w[31:16] : w[15:0];
    case (sz)
      2'b00:   r = sgn ? {{24{b[7]}}, b}  : {24'd0, b};
      2'b01:   r = sgn ? {{16{h[15]}}, h} : {16'd0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  // Replace only the addressed lanes of the old word with right-aligned store data.
  function automatic logic [31:0] merge_store(input logic [31:0] old_w, input logic [31:0] wd,
                                              input logic [1:0] sz, input logic [1:0] off);
    logic [31:0] m;
    m = old_w;
    if (sz == 2'b00) begin
      m[{off, 3'b000} +: 8] = wd[7:0];
    end else if (sz == 2'b01) begin
      if (off[1]) m[31:16] = wd[15:0];
      else        m[15:0]  = wd[15:0];
    end else begin
      m = wd;
    end
    return m;
  endfunction

  assign accept      = req_valid && (state == IDLE);
  assign misaligned  = ((req_size == 2'b01) && req_addr[0]) ||
                       (req_size[1] && (req_addr[1:0] != 2'b00));
  assign op_sub_word = ~op_size[1];
  assign word_idx    = {{(30 - ADDR_BITS){1'b0}}, op_addr[ADDR_BITS+1:2]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      op_write   <= 1'b0;
      op_size    <= 2'b00;
      op_signed  <= 1'b0;
      op_addr    <= '0;
      op_wdata   <= 32'd0;
      merge_word <= 32'd0;
      resp_rdata <= 32'd0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        op_write  <= req_write;
        op_size   <= req_size;
        op_signed <= req_signed;
        op_addr   <= req_addr[ADDR_BITS+1:0];
        op_wdata  <= req_wdata;
        if (misaligned) begin
          resp_rdata <= 32'd0;
          resp_err   <= 1'b1;
        end
      end
      if (state == ACCESS) begin
        resp_err   <= 1'b0;
        resp_rdata <= op_write ? 32'd0
                               : load_extract(mem_dataOut, op_size, op_signed, op_addr[1:0]);
        // The merged word is formed here so WRITE only has to drive it out.
        if (op_write && op_sub_word)
          merge_word <= merge_store(mem_dataOut, op_wdata, op_size, op_addr[1:0]);
      end
    end
  end

  // Memory-side outputs decode straight from the state so reset kills a pending write at once.
  always_comb begin
    state_nxt       = state;
    req_ready       = 1'b0;
    resp_valid      = 1'b0;
    mem_address     = 32'd0;
    mem_writeEnable = 1'b0;
    mem_dataIn      = 32'd0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = misaligned ? RESP : ACCESS;
      end
      ACCESS: begin
        mem_address = word_idx;
        if (op_write && !op_sub_word) begin
          mem_writeEnable = 1'b1;
          mem_dataIn      = op_wdata;
          state_nxt       = RESP;
        end else if (op_write) begin
          state_nxt = WRITE;
        end else begin
          state_nxt = RESP;
        end
      end
      WRITE: begin
        mem_address     = word_idx;
        mem_writeEnable = 1'b1;
        mem_dataIn      = merge_word;
        state_nxt       = RESP;
      end
      RESP: begin
        resp_valid = 1'b1;
        if (resp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed vector table, randomized traffic against a byte-lane memory model,
// response backpressure and reset-during-write sequences for mem_access_unit.
// Ports: none; owns clock, reset, a 1024-word memory model and the request/response drivers.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [31:0] mem_address;
  logic        mem_writeEnable;
  logic [31:0] mem_dataIn;
  logic [31:0] mem_dataOut;

  int checks = 0;
  int errors = 0;

  logic [31:0] mem [0:1023];
  logic [31:0] ref_mem [0:1023];
  logic        pre_we = 1'b0;
  logic [9:0]  pre_addr = 10'd0;
  logic [31:0] pre_data = 32'd0;

  always #5 clk = ~clk;

  mem_access_unit #(.ADDR_BITS(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write), .req_size(req_size),
    .req_signed(req_signed), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_address(mem_address), .mem_writeEnable(mem_writeEnable), .mem_dataIn(mem_dataIn),
    .mem_dataOut(mem_dataOut)
  );

  assign mem_dataOut = mem[mem_address[9:0]];

  always @(posedge clk) begin
    if (pre_we)               mem[pre_addr] <= pre_data;
    else if (mem_writeEnable) mem[mem_address[9:0]] <= mem_dataIn;
  end

  typedef struct {
    logic        w;
    logic [1:0]  sz;
    logic        sg;
    logic [31:0] a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_err;
    int          exp_lat;
    int          exp_wes;
    logic [31:0] exp_addr;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Byte-lane model: shifts and masks on a little-endian word array.
  task automatic ref_access(input logic w, input logic [1:0] sz, input logic sg,
                            input logic [31:0] a, input logic [31:0] wd,
                            output logic [31:0] rd, output logic er, output int lat,
                            output int wes, output logic [31:0] idx);
    int nbytes;
    int sh;
    logic [31:0] mask;
    logic [31:0] word;
    nbytes = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    idx = (a >> 2) % 1024;
    er  = (a % nbytes) != 0;
    rd  = 32'd0;
    lat = 1;
    wes = 0;
    if (er) return;
    sh   = 8 * int'(a % 4);
    mask = (nbytes == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nbytes)) - 32'd1);
    word = ref_mem[idx];
    if (w) begin
      ref_mem[idx] = (word & ~(mask << sh)) | ((wd & mask) << sh);
      wes = 1;
      lat = (nbytes == 4) ? 2 : 3;
    end else begin
      rd = (word >> sh) & mask;
      if (sg && nbytes < 4 && rd[8 * nbytes - 1]) rd = rd | ~mask;
      lat = 2;
    end
  endtask

  // Issues one request from a negedge with the DUT idle, then consumes the response.
  // During hold cycles the response must stay at exp_rd; poke keeps a request pending meanwhile.
  task automatic run_req(input logic w, input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd,
                         input int hold, input logic poke, input logic [31:0] exp_rd,
                         output logic [31:0] rd, output logic er, output int lat,
                         output int wes, output logic [31:0] addr1);
    int cyc;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_write = w; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    cyc = 0; wes = 0; addr1 = 32'd0;
    while (cyc < 8) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) addr1 = mem_address;
      if (mem_writeEnable) wes++;
      if (resp_valid) break;
    end
    lat = resp_valid ? cyc : -1;
    rd  = resp_rdata;
    er  = resp_err;
    if (poke) begin
      req_valid = 1'b1; req_write = 1'b0; req_size = 2'b10; req_addr = 32'h0;
    end
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      chk("hold_resp_valid", 32'(resp_valid), 32'd1);
      chk("hold_resp_rdata", resp_rdata, exp_rd);
      chk("hold_req_ready", 32'(req_ready), 32'd0);
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1 resp_ready = 1'b0;
    req_valid = 1'b0;
    @(negedge clk);
    if (poke) begin
      chk("no_accept_on_resp_edge", 32'(req_ready), 32'd1);
      chk("resp_dropped_after_ready", 32'(resp_valid), 32'd0);
    end
  endtask

  initial begin
    logic [31:0] rd, addr1, m_rd, m_idx;
    logic        er, m_er;
    int          lat, wes, m_lat, m_wes, bad;
    logic        w, sg;
    logic [1:0]  sz;
    logic [31:0] a, wd;

    // Reset and memory preload.
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      pre_we = 1'b1; pre_addr = 10'(i);
      pre_data = (i == 5) ? 32'h80FF7F01 : {8'(i), 8'hC3, ~8'(i), 8'h3C};
      ref_mem[i] = pre_data;
    end
    @(negedge clk);
    pre_we = 1'b0;
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", 32'(resp_err), 32'd0);
    chk("rst_mem_we", 32'(mem_writeEnable), 32'd0);
    chk("rst_mem_dataIn", mem_dataIn, 32'd0);
    chk("rst_mem_address", mem_address, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    //            w     sz     sg    addr          wdata         exp_rd        err   lat wes idx
    tbl[0]  = '{1'b0, 2'b00, 1'b1, 32'h15,       32'h0,        32'h0000007F, 1'b0, 2, 0, 32'd5};
    tbl[1]  = '{1'b0, 2'b00, 1'b1, 32'h16,       32'h0,        32'hFFFFFFFF, 1'b0, 2, 0, 32'd5};
    tbl[2]  = '{1'b0, 2'b01, 1'b0, 32'h16,       32'h0,        32'h000080FF, 1'b0, 2, 0, 32'd5};
    tbl[3]  = '{1'b1, 2'b00, 1'b0, 32'h15,       32'h000000AB, 32'h0,        1'b0, 3, 1, 32'd5};
    tbl[4]  = '{1'b0, 2'b10, 1'b0, 32'h14,       32'h0,        32'h80FFAB01, 1'b0, 2, 0, 32'd5};
    tbl[5]  = '{1'b1, 2'b10, 1'b0, 32'h20,       32'hDEADBEEF, 32'h0,        1'b0, 2, 1, 32'd8};
    tbl[6]  = '{1'b0, 2'b10, 1'b0, 32'h20,       32'h0,        32'hDEADBEEF, 1'b0, 2, 0, 32'd8};
    tbl[7]  = '{1'b0, 2'b10, 1'b0, 32'h22,       32'h0,        32'h0,        1'b1, 1, 0, 32'd0};
    tbl[8]  = '{1'b1, 2'b01, 1'b0, 32'h17,       32'h00001234, 32'h0,        1'b1, 1, 0, 32'd0};
    tbl[9]  = '{1'b0, 2'b01, 1'b1, 32'h16,       32'h0,        32'hFFFF80FF, 1'b0, 2, 0, 32'd5};
    tbl[10] = '{1'b0, 2'b11, 1'b0, 32'h14,       32'h0,        32'h80FFAB01, 1'b0, 2, 0, 32'd5};
    tbl[11] = '{1'b0, 2'b10, 1'b0, 32'h00001020, 32'h0,        32'hDEADBEEF, 1'b0, 2, 0, 32'd8};

    for (int t = 0; t < 12; t++) begin
      ref_access(tbl[t].w, tbl[t].sz, tbl[t].sg, tbl[t].a, tbl[t].wd, m_rd, m_er, m_lat, m_wes, m_idx);
      run_req(tbl[t].w, tbl[t].sz, tbl[t].sg, tbl[t].a, tbl[t].wd, 0, 1'b0, tbl[t].exp_rd,
              rd, er, lat, wes, addr1);
      chk($sformatf("vec%0d_rdata", t), rd, tbl[t].exp_rd);
      chk($sformatf("vec%0d_err", t), 32'(er), 32'(tbl[t].exp_err));
      chk($sformatf("vec%0d_latency", t), 32'(lat), 32'(tbl[t].exp_lat));
      chk($sformatf("vec%0d_we_cycles", t), 32'(wes), 32'(tbl[t].exp_wes));
      if (!tbl[t].exp_err) chk($sformatf("vec%0d_mem_address", t), addr1, tbl[t].exp_addr);
    end

    // Response backpressure with a competing request held on the input.
    ref_access(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, m_rd, m_er, m_lat, m_wes, m_idx);
    run_req(1'b0, 2'b10, 1'b0, 32'h14, 32'h0, 5, 1'b1, 32'h80FFAB01, rd, er, lat, wes, addr1);
    chk("bp_rdata", rd, 32'h80FFAB01);
    chk("bp_latency", 32'(lat), 32'd2);

    // Randomized traffic over words 0..31 with random high address bits.
    for (int n = 0; n < 80; n++) begin
      w  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      sg = 1'($urandom_range(0, 1));
      a  = ($urandom & 32'hFFFF_F000) | 32'($urandom_range(0, 127));
      wd = $urandom;
      ref_access(w, sz, sg, a, wd, m_rd, m_er, m_lat, m_wes, m_idx);
      run_req(w, sz, sg, a, wd, $urandom_range(0, 2), 1'b0, m_rd, rd, er, lat, wes, addr1);
      chk($sformatf("rnd%0d_rdata", n), rd, m_rd);
      chk($sformatf("rnd%0d_err", n), 32'(er), 32'(m_er));
      chk($sformatf("rnd%0d_latency", n), 32'(lat), 32'(m_lat));
      chk($sformatf("rnd%0d_we_cycles", n), 32'(wes), 32'(m_wes));
      if (!m_er) chk($sformatf("rnd%0d_mem_address", n), addr1, m_idx);
    end

    // Reset asserted while a byte store sits in WRITE: the write must never land.
    req_valid = 1'b1; req_write = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h15; req_wdata = 32'h00000011;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("abort_access_we", 32'(mem_writeEnable), 32'd0);
    @(negedge clk);
    chk("abort_write_we", 32'(mem_writeEnable), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_we_drop", 32'(mem_writeEnable), 32'd0);
    chk("abort_dataIn", mem_dataIn, 32'd0);
    chk("abort_address", mem_address, 32'd0);
    chk("abort_req_ready", 32'(req_ready), 32'd1);
    chk("abort_resp_valid", 32'(resp_valid), 32'd0);
    chk("abort_resp_rdata", resp_rdata, 32'd0);
    chk("abort_resp_err", 32'(resp_err), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("abort_mem_word5", mem[5], ref_mem[5]);
    bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid || mem_writeEnable) bad++;
    end
    chk("abort_no_response", 32'(bad), 32'd0);

    // Whole memory image against the model.
    bad = 0;
    for (int i = 0; i < 32; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk("final_mem_image", 32'(bad), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached, got no completion expected completion");
    $fatal(1);
  end

endmodule
